rgb_pixel_unpacker: RTL

Consumes the colour-plane word stream produced by the frame-buffer data fetch stage (one 32-bit red word, then green, then blue, each carrying 8 pixels × 4 bits) and emits 12-bit RGB pixels one per handshake toward the display output stage. It is double-buffered, so a new R/G/B triplet loads while the previous one drains, sustaining one pixel per clock. It also tags pixels with frame and line position markers.

---
 rtl/rgb_pixel_unpacker_pkg.sv | 32 +++
 rtl/rgb_pixel_unpacker_frame_pos_counter.sv | 46 ++++
 rtl/rgb_pixel_unpacker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rgb_pixel_unpacker_pkg.sv
// Shared definitions for the RGB pixel unpacker: fill FSM encoding, word/pixel
// geometry, default frame size and the per-pixel nibble extraction helper.
package rgb_pixel_unpacker_pkg;

  typedef enum logic [1:0] {
    FILL_R = 2'd0,
    FILL_G = 2'd1,
    FILL_B = 2'd2
  } fill_state_t;

  localparam int PIX_PER_WORD = 8;
  localparam int CH_BITS      = 4;
  localparam int WORD_BITS    = PIX_PER_WORD * CH_BITS;
  localparam int PIX_BITS     = 3 * CH_BITS;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  // Pixel k takes nibble k of each colour plane; nibble 0 is the first pixel on screen.
  function automatic logic [PIX_BITS-1:0] pixel_of(
    input logic [WORD_BITS-1:0] r,
    input logic [WORD_BITS-1:0] g,
    input logic [WORD_BITS-1:0] b,
    input logic [IDX_W-1:0]     idx
  );
    int base;
    base = int'(idx) * CH_BITS;
    return {r[base +: CH_BITS], g[base +: CH_BITS], b[base +: CH_BITS]};
  endfunction

endpackage

// File: rtl/rgb_pixel_unpacker_frame_pos_counter.sv
// Raster position tracker: x/y counters advanced per accepted pixel, producing
// start-of-frame and end-of-line markers for the pixel currently on offer.
module frame_pos_counter
  import rgb_pixel_unpacker_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  input  logic advance,
  input  logic valid,
  output logic sof,
  output logic eol
);

  localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_LINES - 1);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (sync_clr) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign sof = valid && (x == '0) && (y == '0);
  assign eol = valid && (x == X_LAST);

endmodule

// File: rtl/rgb_pixel_unpacker.sv
// Converts R, G, B colour-plane words into a stream of 12-bit pixels; a fill
// buffer lets the next triplet land while the shift buffer is still draining.
module rgb_pixel_unpacker
  import rgb_pixel_unpacker_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_clr,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 r_rts,
  input  logic                 g_rts,
  input  logic                 b_rts,
  output logic                 r_rtr,
  output logic                 g_rtr,
  output logic                 b_rtr,
  output logic [PIX_BITS-1:0]  out_pixel,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_rts,
  input  logic                 out_rtr
);

  fill_state_t state, state_next;

  logic [WORD_BITS-1:0] r_hold, g_hold;
  logic [WORD_BITS-1:0] fill_r, fill_g, fill_b;
  logic [WORD_BITS-1:0] shift_r, shift_g, shift_b;
  logic                 fill_full;
  logic [IDX_W-1:0]     pix_idx;

  logic r_xfc, g_xfc, b_xfc, out_xfc, last_xfc, shift_free;

  // Holding R/G back while the fill buffer is occupied keeps r_hold/g_hold intact.
  assign r_rtr = (state == FILL_R) && !fill_full;
  assign g_rtr = (state == FILL_G) && !fill_full;
  assign b_rtr = (state == FILL_B) && !fill_full;

  assign r_xfc      = r_rts && r_rtr;
  assign g_xfc      = g_rts && g_rtr;
  assign b_xfc      = b_rts && b_rtr;
  assign out_xfc    = out_rts && out_rtr;
  assign last_xfc   = out_xfc && (pix_idx == IDX_W'(PIX_PER_WORD - 1));
  assign shift_free = !out_rts || last_xfc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL_R;
    end else if (sync_clr) begin
      state <= FILL_R;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL_R:  if (r_xfc) state_next = FILL_G;
      FILL_G:  if (g_xfc) state_next = FILL_B;
      FILL_B:  if (b_xfc) state_next = FILL_R;
      default: state_next = FILL_R;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      g_hold <= '0;
    end else begin
      if (r_xfc) r_hold <= in_data;
      if (g_xfc) g_hold <= in_data;
    end
  end

  // b_xfc never coincides with fill_full, so direct load and fill-to-shift moves are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= '0;
      shift_g   <= '0;
      shift_b   <= '0;
      fill_r    <= '0;
      fill_g    <= '0;
      fill_b    <= '0;
      fill_full <= 1'b0;
      pix_idx   <= '0;
      out_rts   <= 1'b0;
      out_pixel <= '0;
    end else if (sync_clr) begin
      fill_full <= 1'b0;
      pix_idx   <= '0;
      out_rts   <= 1'b0;
      out_pixel <= '0;
    end else begin
      if (b_xfc && shift_free) begin
        shift_r   <= r_hold;
        shift_g   <= g_hold;
        shift_b   <= in_data;
        pix_idx   <= '0;
        out_rts   <= 1'b1;
        out_pixel <= pixel_of(r_hold, g_hold, in_data, '0);
      end else if (last_xfc && fill_full) begin
        shift_r   <= fill_r;
        shift_g   <= fill_g;
        shift_b   <= fill_b;
        fill_full <= 1'b0;
        pix_idx   <= '0;
        out_pixel <= pixel_of(fill_r, fill_g, fill_b, '0);
      end else if (last_xfc) begin
        pix_idx <= '0;
        out_rts <= 1'b0;
      end else if (out_xfc) begin
        pix_idx   <= pix_idx + 1'b1;
        out_pixel <= pixel_of(shift_r, shift_g, shift_b, pix_idx + 1'b1);
      end

      if (b_xfc && !shift_free) begin
        fill_r    <= r_hold;
        fill_g    <= g_hold;
        fill_b    <= in_data;
        fill_full <= 1'b1;
      end
    end
  end

  frame_pos_counter #(
    .H_PIXELS(H_PIXELS),
    .V_LINES (V_LINES)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .sync_clr(sync_clr),
    .advance (out_xfc),
    .valid   (out_rts),
    .sof     (out_sof),
    .eol     (out_eol)
  );

endmodule
